// File: rtl/cellrv32_sdi_bridge.sv
// SDI command bridge: turns the received SPI byte stream into single-word bus
// accesses and returns status/read-data bytes through the SDI TX FIFO.
module cellrv32_sdi_bridge #(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        frame_i,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_valid_i,
    input  logic        tx_free_i,
    output logic [7:0]  tx_data_o,
    output logic        tx_we_o,
    output logic [31:0] bus_addr_o,
    output logic [31:0] bus_wdata_o,
    output logic [3:0]  bus_ben_o,
    output logic        bus_we_o,
    output logic        bus_re_o,
    input  logic [31:0] bus_data_i,
    input  logic        bus_ack_i,
    input  logic        bus_err_i,
    output logic        busy_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ADDR  = 3'd1,
        S_WDATA = 3'd2,
        S_BUS   = 3'd3,
        S_RESP  = 3'd4
    } state_t;

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYC - 1);

    state_t      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        is_rd_q, is_rd_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic [7:0]  stat_q, stat_d;
    logic        stat_sent_q, stat_sent_d;
    logic        drop_q, drop_d;
    logic [15:0] tmo_q, tmo_d;
    logic        we_q, we_d;
    logic        re_q, re_d;
    logic        tx_we_s;
    logic        done_s;

    // Next-state logic for command parsing, bus access and response push.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        is_rd_d     = is_rd_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        stat_d      = stat_q;
        stat_sent_d = stat_sent_q;
        drop_d      = drop_q;
        tmo_d       = tmo_q;
        we_d        = 1'b0;
        re_d        = 1'b0;
        tx_we_s     = 1'b0;
        done_s      = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d       = 2'd0;
                tmo_d       = 16'd0;
                drop_d      = 1'b0;
                stat_sent_d = 1'b0;
                if (rx_valid_i) begin
                    case (rx_data_i)
                        8'h01: begin is_rd_d = 1'b0; state_d = S_ADDR; end
                        8'h02: begin is_rd_d = 1'b1; state_d = S_ADDR; end
                        8'h03: begin is_rd_d = 1'b0; stat_d = 8'hA5; state_d = S_RESP; end
                        default: begin is_rd_d = 1'b0; stat_d = 8'hE3; state_d = S_RESP; end
                    endcase
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ADDR: begin
                if (!frame_i) begin
                    state_d = S_IDLE;
                end else if (rx_valid_i) begin
                    addr_d = {addr_q[23:0], rx_data_i};
                    cnt_d  = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        if (is_rd_q) begin
                            state_d = S_BUS;
                            re_d    = 1'b1;
                        end else begin
                            state_d = S_WDATA;
                        end
                    end else begin
                        state_d = S_ADDR;
                    end
                end else begin
                    state_d = S_ADDR;
                end
            end
            S_WDATA: begin
                if (!frame_i) begin
                    state_d = S_IDLE;
                end else if (rx_valid_i) begin
                    wdata_d = {wdata_q[23:0], rx_data_i};
                    cnt_d   = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        state_d = S_BUS;
                        we_d    = 1'b1;
                    end else begin
                        state_d = S_WDATA;
                    end
                end else begin
                    state_d = S_WDATA;
                end
            end
            S_BUS: begin
                tmo_d  = (tmo_q == 16'hFFFF) ? tmo_q : tmo_q + 16'd1;
                drop_d = drop_q | ~frame_i;
                // Error outranks ack when both arrive together.
                if (bus_err_i) begin
                    stat_d  = 8'hE1;
                    rdata_d = 32'h0000_0000;
                    done_s  = 1'b1;
                end else if (bus_ack_i) begin
                    stat_d  = 8'hA5;
                    rdata_d = is_rd_q ? bus_data_i : 32'h0000_0000;
                    done_s  = 1'b1;
                end else if (tmo_q >= TMO_LAST) begin
                    stat_d  = 8'hE2;
                    rdata_d = 32'h0000_0000;
                    done_s  = 1'b1;
                end else begin
                    done_s  = 1'b0;
                end
                if (done_s) begin
                    stat_sent_d = 1'b0;
                    cnt_d       = 2'd0;
                    state_d     = (drop_q || !frame_i) ? S_IDLE : S_RESP;
                end else begin
                    state_d = S_BUS;
                end
            end
            S_RESP: begin
                tx_we_s = tx_free_i;
                if (tx_free_i) begin
                    if (!stat_sent_q) begin
                        stat_sent_d = 1'b1;
                        state_d     = is_rd_q ? S_RESP : S_IDLE;
                    end else begin
                        rdata_d = {rdata_q[23:0], 8'h00};
                        cnt_d   = cnt_q + 2'd1;
                        state_d = (cnt_q == 2'd3) ? S_IDLE : S_RESP;
                    end
                end else begin
                    state_d = S_RESP;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q     <= S_IDLE;
            cnt_q       <= 2'd0;
            is_rd_q     <= 1'b0;
            addr_q      <= 32'h0000_0000;
            wdata_q     <= 32'h0000_0000;
            rdata_q     <= 32'h0000_0000;
            stat_q      <= 8'h00;
            stat_sent_q <= 1'b0;
            drop_q      <= 1'b0;
            tmo_q       <= 16'd0;
            we_q        <= 1'b0;
            re_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            is_rd_q     <= is_rd_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            stat_q      <= stat_d;
            stat_sent_q <= stat_sent_d;
            drop_q      <= drop_d;
            tmo_q       <= tmo_d;
            we_q        <= we_d;
            re_q        <= re_d;
        end
    end

    // tx_we_o must follow tx_free_i in the same cycle so a full FIFO never sees a write.
    assign tx_we_o     = tx_we_s;
    assign tx_data_o   = (state_q != S_RESP) ? 8'h00 :
                         (stat_sent_q ? rdata_q[31:24] : stat_q);
    assign bus_addr_o  = {addr_q[31:2], 2'b00};
    assign bus_wdata_o = wdata_q;
    assign bus_ben_o   = (state_q == S_BUS) ? 4'b1111 : 4'b0000;
    assign bus_we_o    = we_q;
    assign bus_re_o    = re_q;
    assign busy_o      = (state_q != S_IDLE);

endmodule

// File: tb/tb_cellrv32_sdi_bridge.sv
// Directed self-checking bench for cellrv32_sdi_bridge (built with TIMEOUT_CYC = 8).
module tb_cellrv32_sdi_bridge;

    logic        clk = 1'b0;
    logic        rstn;
    logic        frame;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        tx_free = 1'b1;
    logic [7:0]  tx_data;
    logic        tx_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_ben;
    logic        bus_we;
    logic        bus_re;
    logic [31:0] bus_data;
    logic        bus_ack;
    logic        bus_err;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    // Written only by the monitor / free driver processes.
    int          cyc = 0;
    int          we_cnt = 0;
    int          re_cnt = 0;
    int          bad_we = 0;
    int          pulse_cyc = 0;
    logic [31:0] cap_addr = 32'h0;
    logic [31:0] cap_wdata = 32'h0;
    logic [3:0]  cap_ben = 4'h0;
    logic [7:0]  txq[$];
    int          txcyc[$];
    logic        bp_en = 1'b0;
    int          bp_idx = 0;

    cellrv32_sdi_bridge #(.TIMEOUT_CYC(8)) dut (
        .clk_i       (clk),
        .rstn_i      (rstn),
        .frame_i     (frame),
        .rx_data_i   (rx_data),
        .rx_valid_i  (rx_valid),
        .tx_free_i   (tx_free),
        .tx_data_o   (tx_data),
        .tx_we_o     (tx_we),
        .bus_addr_o  (bus_addr),
        .bus_wdata_o (bus_wdata),
        .bus_ben_o   (bus_ben),
        .bus_we_o    (bus_we),
        .bus_re_o    (bus_re),
        .bus_data_i  (bus_data),
        .bus_ack_i   (bus_ack),
        .bus_err_i   (bus_err),
        .busy_o      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // FIFO space: always free, or the 1,0,0,1 pattern during the backpressure test.
    always begin
        @(posedge clk);
        #1;
        if (bp_en) begin
            tx_free = ((bp_idx % 4) == 0) || ((bp_idx % 4) == 3);
            bp_idx  = bp_idx + 1;
        end else begin
            tx_free = 1'b1;
        end
    end

    // Observe the DUT mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (bus_we) begin
            we_cnt    <= we_cnt + 1;
            cap_addr  <= bus_addr;
            cap_wdata <= bus_wdata;
            cap_ben   <= bus_ben;
            pulse_cyc <= cyc;
        end
        if (bus_re) begin
            re_cnt    <= re_cnt + 1;
            cap_addr  <= bus_addr;
            cap_ben   <= bus_ben;
            pulse_cyc <= cyc;
        end
        if (tx_we) begin
            txq.push_back(tx_data);
            txcyc.push_back(cyc);
            if (!tx_free) bad_we <= bad_we + 1;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Wait (bounded) for the request pulse, then answer after dly cycles.
    task automatic bus_reply(input int dly, input logic ack, input logic err, input logic [31:0] d);
        int k;
        for (k = 0; k < 20; k++) begin
            if (bus_we || bus_re) break;
            step(1);
        end
        check_eq("bus_pulse_seen", 32'(k < 20), 32'd1);
        step(dly);
        bus_ack  = ack;
        bus_err  = err;
        bus_data = d;
        step(1);
        bus_ack  = 1'b0;
        bus_err  = 1'b0;
        bus_data = 32'h0;
    endtask

    task automatic wait_idle(input string tag, input int bound);
        for (int k = 0; k < bound; k++) begin
            if (!busy) break;
            step(1);
        end
        check_eq(tag, 32'(busy), 32'd0);
    endtask

    task automatic check_tx(input string tag, input int base, input logic [39:0] exp, input int n);
        int sz;
        sz = txq.size() - base;
        check_eq({tag, "_count"}, 32'(sz), 32'(n));
        for (int i = 0; i < n; i++) begin
            if (i < sz) check_eq({tag, "_byte"}, 32'(txq[base + i]), 32'(exp[8*(n-1-i) +: 8]));
        end
    endtask

    int tb_base, we_base, re_base, bad_base;

    initial begin
        rstn = 1'b0; frame = 1'b0; rx_data = 8'h00; rx_valid = 1'b0;
        bus_data = 32'h0; bus_ack = 1'b0; bus_err = 1'b0;
        step(3);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_tx_we", 32'(tx_we), 32'd0);
        check_eq("rst_bus_we", 32'(bus_we), 32'd0);
        check_eq("rst_bus_re", 32'(bus_re), 32'd0);
        check_eq("rst_addr", bus_addr, 32'h0);
        check_eq("rst_ben", 32'(bus_ben), 32'h0);
        rstn = 1'b1;
        frame = 1'b1;
        step(2);

        // WRITE 0x80000010 <- 0xDEADBEEF, ack after 3 cycles
        tb_base = txq.size(); we_base = we_cnt; re_base = re_cnt;
        send_byte(8'h01); send_byte(8'h80); send_byte(8'h00); send_byte(8'h00); send_byte(8'h10);
        send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE);
        send_byte(8'hEF);
        check_eq("wr_we_latency", 32'(bus_we), 32'd1);
        bus_reply(3, 1'b1, 1'b0, 32'h0);
        wait_idle("wr_idle", 20);
        check_eq("wr_we_pulses", 32'(we_cnt - we_base), 32'd1);
        check_eq("wr_re_pulses", 32'(re_cnt - re_base), 32'd0);
        check_eq("wr_addr", cap_addr, 32'h8000_0010);
        check_eq("wr_wdata", cap_wdata, 32'hDEAD_BEEF);
        check_eq("wr_ben", 32'(cap_ben), 32'hF);
        check_tx("wr_tx", tb_base, 40'h00_0000_00A5, 1);

        // READ 0x00000004 -> 0x12345678
        tb_base = txq.size(); re_base = re_cnt;
        send_byte(8'h02); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h04);
        bus_reply(2, 1'b1, 1'b0, 32'h1234_5678);
        wait_idle("rd_idle", 20);
        check_eq("rd_re_pulses", 32'(re_cnt - re_base), 32'd1);
        check_eq("rd_addr", cap_addr, 32'h0000_0004);
        check_tx("rd_tx", tb_base, 40'hA5_1234_5678, 5);

        // READ with no response: timeout after 8 cycles
        tb_base = txq.size();
        send_byte(8'h02); send_byte(8'h00); send_byte(8'h00); send_byte(8'h01); send_byte(8'h00);
        wait_idle("tmo_idle", 30);
        check_tx("tmo_tx", tb_base, 40'hE2_0000_0000, 5);
        if (txq.size() > tb_base)
            check_eq("tmo_latency", 32'(txcyc[tb_base] - pulse_cyc), 32'd8);

        // ack and err together: error status wins
        tb_base = txq.size();
        send_byte(8'h02); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h08);
        bus_reply(1, 1'b1, 1'b1, 32'hFFFF_FFFF);
        wait_idle("err_idle", 20);
        check_tx("err_tx", tb_base, 40'hE1_0000_0000, 5);

        // Abort in ADDR, then ping
        tb_base = txq.size(); we_base = we_cnt; re_base = re_cnt;
        send_byte(8'h01); send_byte(8'h80); send_byte(8'h00);
        frame = 1'b0;
        step(2);
        check_eq("abort_busy", 32'(busy), 32'd0);
        check_eq("abort_pulses", 32'(we_cnt - we_base + re_cnt - re_base), 32'd0);
        check_eq("abort_tx", 32'(txq.size() - tb_base), 32'd0);
        frame = 1'b1;
        send_byte(8'h03);
        wait_idle("ping_idle", 10);
        check_tx("ping_tx", tb_base, 40'h00_0000_00A5, 1);

        // frame dropped during BUS: access completes, no response
        tb_base = txq.size(); re_base = re_cnt;
        send_byte(8'h02); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h0C);
        frame = 1'b0;
        bus_reply(2, 1'b1, 1'b0, 32'hCAFE_F00D);
        wait_idle("drop_idle", 20);
        check_eq("drop_re_pulses", 32'(re_cnt - re_base), 32'd1);
        check_eq("drop_tx", 32'(txq.size() - tb_base), 32'd0);
        frame = 1'b1;

        // Backpressure during a READ response
        tb_base = txq.size(); bad_base = bad_we;
        bp_en = 1'b1;
        send_byte(8'h02); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h10);
        bus_reply(0, 1'b1, 1'b0, 32'h0BAD_CAFE);
        wait_idle("bp_idle", 40);
        bp_en = 1'b0;
        check_tx("bp_tx", tb_base, 40'hA5_0BAD_CAFE, 5);
        check_eq("bp_we_while_full", 32'(bad_we - bad_base), 32'd0);

        // Bad command
        tb_base = txq.size();
        send_byte(8'h7F);
        wait_idle("bad_idle", 10);
        check_tx("bad_tx", tb_base, 40'h00_0000_00E3, 1);

        // Asynchronous reset in WDATA
        we_base = we_cnt;
        send_byte(8'h01); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h20);
        send_byte(8'hAA);
        check_eq("pre_rst_busy", 32'(busy), 32'd1);
        rstn = 1'b0;
        #1;
        check_eq("arst_busy", 32'(busy), 32'd0);
        check_eq("arst_addr", bus_addr, 32'h0);
        check_eq("arst_wdata", bus_wdata, 32'h0);
        check_eq("arst_outs", {24'h0, tx_data}, 32'h0);
        check_eq("arst_strobes", 32'({tx_we, bus_we, bus_re, bus_ben}), 32'h0);
        #2;
        rstn = 1'b1;
        step(2);
        tb_base = txq.size();
        send_byte(8'h03);
        wait_idle("post_rst_idle", 10);
        check_tx("post_rst_tx", tb_base, 40'h00_0000_00A5, 1);
        check_eq("post_rst_no_write", 32'(we_cnt - we_base), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
